// File: rtl/key_press_gen.sv
// key_press_gen: turns byte-plus-key commands into timed active-low key presses
// and a held num1 switch value, suitable for feeding a two-flop press detector.
module key_press_gen #(
  parameter int SETUP_CYCLES = 2,
  parameter int PRESS_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_key,
  input  logic [7:0] cmd_data,
  output logic [7:0] num1,
  output logic       reset_key,
  output logic       write_key,
  output logic       move_key,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PRESS, S_GAP} state_t;

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [1:0]       r_key;
  logic [7:0]       r_num1;
  logic [2:0]       r_keys_n, w_keys_n_next;  // {move, write, reset}, active low
  logic             r_done, w_done_next;
  logic             w_accept;
  logic             w_cnt_zero;

  assign cmd_ready  = (r_state == S_IDLE) & ~reset;
  assign busy       = (r_state != S_IDLE);
  assign w_accept   = cmd_valid & cmd_ready;
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_key    <= 2'd0;
      r_num1   <= 8'h00;
      r_keys_n <= 3'b111;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_keys_n <= w_keys_n_next;
      r_done   <= w_done_next;
      if (w_accept) begin
        r_key  <= cmd_key;
        r_num1 <= cmd_data;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_SETUP;
          w_cnt_next   = SETUP_LOAD;
        end
      end
      S_SETUP: begin
        if (w_cnt_zero) begin
          w_state_next = S_PRESS;
          w_cnt_next   = PRESS_LOAD;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_PRESS: begin
        if (w_cnt_zero) begin
          w_state_next = S_GAP;
          w_cnt_next   = GAP_LOAD;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_GAP: begin
        if (w_cnt_zero) begin
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Keys are computed from the next state so the registered lines are low
  // exactly while the state register holds PRESS.
  always_comb begin
    w_done_next   = (r_state == S_GAP) & w_cnt_zero;
    w_keys_n_next = 3'b111;
    if (w_state_next == S_PRESS) begin
      case (r_key)
        2'd0:    w_keys_n_next = 3'b110;
        2'd1:    w_keys_n_next = 3'b101;
        2'd2:    w_keys_n_next = 3'b011;
        default: w_keys_n_next = 3'b111;
      endcase
    end
  end

  assign num1      = r_num1;
  assign reset_key = r_keys_n[0];
  assign write_key = r_keys_n[1];
  assign move_key  = r_keys_n[2];
  assign done      = r_done;

endmodule

// File: tb/tb_key_press_gen.sv
// Bench for key_press_gen: two configurations (defaults and all-ones timing),
// a command timeline model fed on acceptance and checked every cycle.
module tb_key_press_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         acc;
    logic [1:0] key;
    logic [7:0] data;
  } exp_t;

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s inst=%0d cycle=%0d actual=%0h required=%0h", name, inst, cyc, act, req);
    end
  endtask

  task automatic fail_now(input string name, input int inst);
    checks++;
    errors++;
    $display("FAIL %s inst=%0d cycle=%0d actual=expired required=event", name, inst, cyc);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int S = (gi == 0) ? 2 : 1;
    localparam int P = (gi == 0) ? 4 : 1;
    localparam int G = (gi == 0) ? 4 : 1;

    logic       reset, cmd_valid, cmd_ready;
    logic [1:0] cmd_key;
    logic [7:0] cmd_data, num1;
    logic       reset_key, write_key, move_key, busy, done;

    exp_t       q[$];
    logic [7:0] last_num1 = 8'h00;
    bit         armed = 1'b0;
    bit         fin_flag = 1'b0;
    int         t, exp_low;
    logic       exp_busy, exp_done;
    logic [7:0] exp_num1;

    key_press_gen #(
      .SETUP_CYCLES(S), .PRESS_CYCLES(P), .GAP_CYCLES(G), .CNT_W(8)
    ) u_dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_key(cmd_key), .cmd_data(cmd_data), .num1(num1),
      .reset_key(reset_key), .write_key(write_key), .move_key(move_key),
      .busy(busy), .done(done)
    );

    // Stimulus side: every accepted command pushes its expected timeline.
    always @(negedge clk) begin
      if (cmd_valid === 1'b1 && cmd_ready === 1'b1 && reset === 1'b0)
        q.push_back('{acc: cyc, key: cmd_key, data: cmd_data});
    end

    // Monitor: derive expected outputs from the oldest in-flight command.
    always @(negedge clk) begin
      if (armed) begin
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_low  = 4;
        exp_num1 = last_num1;
        if (q.size() > 0 && cyc > q[0].acc) begin
          t        = cyc - q[0].acc;
          exp_num1 = q[0].data;
          exp_busy = (t <= S + P + G);
          exp_done = (t == S + P + G + 1);
          if (t >= S + 1 && t <= S + P) exp_low = int'(q[0].key);
        end
        chk("reset_key", gi, reset_key, (exp_low == 0) ? 0 : 1);
        chk("write_key", gi, write_key, (exp_low == 1) ? 0 : 1);
        chk("move_key", gi, move_key, (exp_low == 2) ? 0 : 1);
        chk("busy", gi, busy, exp_busy);
        chk("done", gi, done, exp_done);
        chk("num1", gi, num1, exp_num1);
        chk("cmd_ready", gi, cmd_ready, !exp_busy && !reset);
        if (exp_done) begin
          $display("inst=%0d cmd key=%0d data=%02h accepted=%0d done=%0d",
                   gi, q[0].key, q[0].data, q[0].acc, cyc);
          last_num1 = q[0].data;
          void'(q.pop_front());
        end
      end
      if (reset === 1'b1) begin
        armed     = 1'b1;
        last_num1 = 8'h00;
        q.delete();
      end
    end

    task automatic send(input logic [1:0] k, input logic [7:0] d, input bit hold);
      int n = 0;
      cmd_key   = k;
      cmd_data  = d;
      cmd_valid = 1'b1;
      do begin
        @(negedge clk);
        n++;
      end while (cmd_ready !== 1'b1 && n < 300);
      if (cmd_ready !== 1'b1) fail_now("accept_timeout", gi);
      @(posedge clk);
      #1;
      if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while ((q.size() != 0 || busy !== 1'b0) && n < 300);
      if (q.size() != 0 || busy !== 1'b0) fail_now("idle_timeout", gi);
      @(posedge clk);
      #1;
    endtask

    initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_key   = 2'd0;
      cmd_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      send(2'd1, 8'hA5, 1'b0);
      wait_idle();

      // back-to-back: valid stays high across the first done cycle
      send(2'd1, 8'h3C, 1'b1);
      send(2'd2, 8'h3C, 1'b0);
      wait_idle();

      send(2'd3, 8'h7E, 1'b0);
      wait_idle();

      // reset lands during the press (gap for the single-cycle configuration)
      send(2'd1, 8'h5A, 1'b0);
      repeat (S + 1) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      send(2'd0, 8'h11, 1'b0);
      wait_idle();

      for (int i = 0; i < 600; i++) begin
        cmd_valid = ($urandom_range(0, 2) == 0);
        cmd_key   = 2'($urandom_range(0, 3));
        cmd_data  = 8'($urandom);
        reset     = ($urandom_range(0, 199) == 0);
        @(posedge clk);
        #1;
      end
      reset     = 1'b0;
      cmd_valid = 1'b0;
      wait_idle();
      fin_flag = 1'b1;
    end
  end

  initial begin
    bit ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (g_cfg[0].fin_flag && g_cfg[1].fin_flag) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("run_timeout", 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
